video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Pixel-clock-domain raster timing generator for the HDMI overlay pipeline. Sits directly upstream of the DE stage: produces hSync, vSync, deOut and the pixel position counters (hCount, vCount) that the DE, overlay and video-out stages consume. Default timing is CEA-861 1080p60 (148.5 MHz pixel clock).

Parameters:
busWidth, 12, counter/position width; must hold hTotal-1 and vTotal-1
resHorizontal, 1920, active pixels per line
hFrontPorch, 88, pixels
hSyncWidth, 44, pixels
hBackPorch, 148, pixels
resVertical, 1080, active lines per frame
vFrontPorch, 4, lines
vSyncWidth, 5, lines
vBackPorch, 36, lines
hSyncPol, 1'b1, active level of hSync
vSyncPol, 1'b1, active level of vSync

Ports:
clk  in  1  pixel clock
rstN  in  1  asynchronous active-low reset
enable  in  1  advance raster by one pixel per clk when high
hSync  out  1  horizontal sync, polarity hSyncPol
vSync  out  1  vertical sync, polarity vSyncPol
deOut  out  1  high inside the active area
hCount  out  busWidth  horizontal position of current pixel
vCount  out  busWidth  vertical position of current line
frameStart  out  1  single-cycle pulse at position (0,0)
rgbOut  out  24  test pattern {R,G,B}, see Optional Feature

Behaviour:
- hTotal = resHorizontal+hFrontPorch+hSyncWidth+hBackPorch (2200); vTotal likewise (1125).
- Single clock; rstN asynchronous assert, all state registered.
- Reset values: hCount = hTotal-1, vCount = vTotal-1, deOut = 0, frameStart = 0, hSync = ~hSyncPol, vSync = ~vSyncPol, rgbOut = 0.
- First enabled edge after reset moves to (0,0): deOut = 1, frameStart = 1.
- All outputs registered and mutually aligned: in any cycle, hSync/vSync/deOut/frameStart/rgbOut describe the pixel at (hCount, vCount). No relative latency between outputs.
- enable low: counters and all outputs hold their values (frameStart included, hold not re-pulse: frameStart forced 0 while enable low).
- Horizontal: hCount 0..hTotal-1, wraps to 0. Vertical: vCount increments only when hCount wraps; wraps 0 after vTotal-1.
- deOut = (hCount < resHorizontal) && (vCount < resVertical).
- hSync active for hCount in [resHorizontal+hFrontPorch, resHorizontal+hFrontPorch+hSyncWidth-1] (2008..2051).
- vSync active for vCount in [resVertical+vFrontPorch, resVertical+vFrontPorch+vSyncWidth-1] (1084..1088), whole lines, transitions at hCount = 0.
- frameStart high only when (hCount,vCount) = (0,0) and enable was high on that edge.
- Reset mid-frame: immediate return to reset values; no partial pulse.
- Parameter legality (all >= 1, totals fit busWidth) checked at elaboration; illegal set is a fatal error.

Optional Feature:
Macro VIDEO_TIMING_COLOR_BAR_EN.
- Defined: rgbOut carries 8 vertical colour bars, each resHorizontal/8 pixels wide (240), order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000; rgbOut = 0 whenever deOut = 0; aligned with deOut.
- Undefined: rgbOut tied to 24'h0; no bar logic synthesized.

Decomposition:
- Package video_timing_pkg: 1080p60 and 720p60 timing constant sets, hTotal/vTotal derivation functions, colour-bar RGB constants, sync-window compare function.
- Sub-module timing_axis_counter (wrap counter with enable, carry-in, wrap-out, reset-to-max), instantiated once per axis; vertical carry-in = horizontal wrap-out.

Test Plan:
- Reset release, enable=1, default params -> first edge (0,0), deOut=1, frameStart=1; hSync asserts at hCount 2008, deasserts at 2052; vSync high for vCount 1084..1088.
- Small params (8/2/2/2 H, 4/1/1/1 V) -> hTotal 14, vTotal 7; frameStart every 98 cycles; deOut count per frame = 32.
- enable toggled 0 for 5 cycles at hCount 3 -> counters/outputs frozen, frameStart 0, resume at hCount 4.
- rstN pulsed low at (5,2) mid-frame -> outputs immediately at reset values; next enabled edge (0,0) with frameStart=1.
- hSyncPol=0, vSyncPol=0 -> syncs idle high, low in same windows as default test.
- VIDEO_TIMING_COLOR_BAR_EN defined, default params -> rgbOut FFFFFF at hCount 0, FFFF00 at 240, 000000 at 1680..1919, 0 at hCount 1920 and in vertical blanking.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the video timing generator.
// Colour-bar helpers are only referenced when VIDEO_TIMING_COLOR_BAR_EN is defined.
package video_timing_pkg;

    typedef struct packed {
        int active;
        int frontPorch;
        int syncWidth;
        int backPorch;
    } axisTiming;

    localparam axisTiming h1080p60 = '{active: 1920, frontPorch: 88,  syncWidth: 44, backPorch: 148};
    localparam axisTiming v1080p60 = '{active: 1080, frontPorch: 4,   syncWidth: 5,  backPorch: 36};
    localparam axisTiming h720p60  = '{active: 1280, frontPorch: 110, syncWidth: 40, backPorch: 220};
    localparam axisTiming v720p60  = '{active: 720,  frontPorch: 5,   syncWidth: 5,  backPorch: 20};

    localparam int numBars = 8;

    localparam logic [23:0] colorWhite   = 24'hFFFFFF;
    localparam logic [23:0] colorYellow  = 24'hFFFF00;
    localparam logic [23:0] colorCyan    = 24'h00FFFF;
    localparam logic [23:0] colorGreen   = 24'h00FF00;
    localparam logic [23:0] colorMagenta = 24'hFF00FF;
    localparam logic [23:0] colorRed     = 24'hFF0000;
    localparam logic [23:0] colorBlue    = 24'h0000FF;
    localparam logic [23:0] colorBlack   = 24'h000000;

    function automatic int axisTotal(input int active, input int frontPorch,
                                     input int syncWidth, input int backPorch);
        return active + frontPorch + syncWidth + backPorch;
    endfunction

    // True when pos lies in [start, start+len-1].
    function automatic logic inWindow(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

    function automatic int barIndex(input int pos, input int barWidth);
        int idx;
        idx = 0;
        for (int k = 1; k < numBars; k++) begin
            if (pos >= k * barWidth) idx = k;
        end
        return idx;
    endfunction

    function automatic logic [23:0] barColor(input int idx);
        case (idx)
            0:       return colorWhite;
            1:       return colorYellow;
            2:       return colorCyan;
            3:       return colorGreen;
            4:       return colorMagenta;
            5:       return colorRed;
            6:       return colorBlue;
            default: return colorBlack;
        endcase
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping position counter for one raster axis: steps on enable&carryIn,
// wraps after maxCount, resets to maxCount so the first step lands on 0.
module timing_axis_counter #(
    parameter int busWidth = 12,
    parameter int maxCount = 1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                enable,
    input  logic                carryIn,
    output logic [busWidth-1:0] count,
    output logic [busWidth-1:0] nextCount,
    output logic                wrapOut
);

    localparam logic [busWidth-1:0] maxValue = busWidth'(maxCount);

    logic atMax;
    logic step;

    assign atMax   = (count == maxValue);
    assign step    = enable && carryIn;
    assign wrapOut = step && atMax;

    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
        nextCount = count;
        if (step) nextCount = atMax ? '0 : count + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) count <= maxValue;
        else       count <= nextCount;
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered, mutually aligned syncs, DE, positions.
// Define VIDEO_TIMING_COLOR_BAR_EN to drive an 8-bar test pattern on rgbOut.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   busWidth      = 12,
    parameter int   resHorizontal = h1080p60.active,
    parameter int   hFrontPorch   = h1080p60.frontPorch,
    parameter int   hSyncWidth    = h1080p60.syncWidth,
    parameter int   hBackPorch    = h1080p60.backPorch,
    parameter int   resVertical   = v1080p60.active,
    parameter int   vFrontPorch   = v1080p60.frontPorch,
    parameter int   vSyncWidth    = v1080p60.syncWidth,
    parameter int   vBackPorch    = v1080p60.backPorch,
    parameter logic hSyncPol      = 1'b1,
    parameter logic vSyncPol      = 1'b1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                enable,
    output logic                hSync,
    output logic                vSync,
    output logic                deOut,
    output logic [busWidth-1:0] hCount,
    output logic [busWidth-1:0] vCount,
    output logic                frameStart,
    output logic [23:0]         rgbOut
);

    localparam int hTotal     = axisTotal(resHorizontal, hFrontPorch, hSyncWidth, hBackPorch);
    localparam int vTotal     = axisTotal(resVertical, vFrontPorch, vSyncWidth, vBackPorch);
    localparam int hSyncStart = resHorizontal + hFrontPorch;
    localparam int vSyncStart = resVertical + vFrontPorch;

    if (busWidth < 1 || busWidth > 31 ||
        resHorizontal < 1 || hFrontPorch < 1 || hSyncWidth < 1 || hBackPorch < 1 ||
        resVertical < 1 || vFrontPorch < 1 || vSyncWidth < 1 || vBackPorch < 1 ||
        ((hTotal - 1) >> busWidth) != 0 || ((vTotal - 1) >> busWidth) != 0) begin : gIllegalParams
        $fatal(1, "video_timing_gen: illegal timing parameter set");
    end

    logic [busWidth-1:0] hNext;
    logic [busWidth-1:0] vNext;
    logic                hWrap;
    logic                vWrap;
    logic                activeNext;

    timing_axis_counter #(
        .busWidth (busWidth),
        .maxCount (hTotal - 1)
    ) uHorizontal (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .carryIn   (1'b1),
        .count     (hCount),
        .nextCount (hNext),
        .wrapOut   (hWrap)
    );

    timing_axis_counter #(
        .busWidth (busWidth),
        .maxCount (vTotal - 1)
    ) uVertical (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .carryIn   (hWrap),
        .count     (vCount),
        .nextCount (vNext),
        .wrapOut   (vWrap)
    );

    // Outputs are decoded from the counters' next values so they land in the same
    // cycle as the position they describe.
    assign activeNext = (int'(hNext) < resHorizontal) && (int'(vNext) < resVertical);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hSync      <= ~hSyncPol;
            vSync      <= ~vSyncPol;
            deOut      <= 1'b0;
            frameStart <= 1'b0;
        end else if (enable) begin
            hSync      <= inWindow(int'(hNext), hSyncStart, hSyncWidth) ? hSyncPol : ~hSyncPol;
            vSync      <= inWindow(int'(vNext), vSyncStart, vSyncWidth) ? vSyncPol : ~vSyncPol;
            deOut      <= activeNext;
            frameStart <= vWrap;
        end else begin
            frameStart <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_COLOR_BAR_EN
    localparam int barWidth = resHorizontal / numBars;

    logic [23:0] rgbNext;

    always_comb begin
        rgbNext = 24'h0;
        if (activeNext) rgbNext = barColor(barIndex(int'(hNext), barWidth));
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       rgbOut <= 24'h0;
        else if (enable) rgbOut <= rgbNext;
    end
`else
    assign rgbOut = 24'h0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: default, inverted-polarity and small rasters.
module tb_video_timing_gen;

    localparam int A = 0;
    localparam int P = 1;
    localparam int S = 2;

    typedef struct {
        int dut;
        int cyc;
        int k;
        int h;
        int v;
        int hs;
        int vs;
        int de;
        int fs;
        int rgb;
    } expT;

    logic clk = 1'b0;
    logic rstN, en, rstS, enS;
    int   cyc = 0;
    int   base;
    int   total = 0;
    int   bad = 0;
    expT  sb[$];

    logic        aHs, aVs, aDe, aFs, pHs, pVs, pDe, pFs, sHs, sVs, sDe, sFs;
    logic [11:0] aH, aV, pH, pV, sH, sV;
    logic [23:0] aRgb, pRgb, sRgb;

    logic cntOn = 1'b0;
    int   deCnt = 0;
    int   fsCyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_timing_gen dA (
        .clk(clk), .rstN(rstN), .enable(en), .hSync(aHs), .vSync(aVs), .deOut(aDe),
        .hCount(aH), .vCount(aV), .frameStart(aFs), .rgbOut(aRgb)
    );

    video_timing_gen #(
        .resVertical(4), .vFrontPorch(1), .vSyncWidth(2), .vBackPorch(1),
        .hSyncPol(1'b0), .vSyncPol(1'b0)
    ) dP (
        .clk(clk), .rstN(rstN), .enable(en), .hSync(pHs), .vSync(pVs), .deOut(pDe),
        .hCount(pH), .vCount(pV), .frameStart(pFs), .rgbOut(pRgb)
    );

    video_timing_gen #(
        .resHorizontal(8), .hFrontPorch(2), .hSyncWidth(2), .hBackPorch(2),
        .resVertical(4), .vFrontPorch(1), .vSyncWidth(1), .vBackPorch(1)
    ) dS (
        .clk(clk), .rstN(rstS), .enable(enS), .hSync(sHs), .vSync(sVs), .deOut(sDe),
        .hCount(sH), .vCount(sV), .frameStart(sFs), .rgbOut(sRgb)
    );

    function automatic int bar(input logic [23:0] c);
`ifdef VIDEO_TIMING_COLOR_BAR_EN
        return int'(c);
`else
        return (c == 24'h0) ? 0 : 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectAt(input int dut, input int k, input int h, input int v, input int hs,
                            input int vs, input int de, input int fs, input int rgb);
        expT e;
        e = '{dut, base + k, k, h, v, hs, vs, de, fs, rgb};
        sb.push_back(e);
    endtask

    task automatic waitCyc(input int t);
        while (cyc < t) @(negedge clk);
        #1;
    endtask

    task automatic compare(input expT e);
        int    h, v, hs, vs, de, fs, rgb;
        string tag;
        case (e.dut)
            A: begin
                tag = "A"; h = int'(aH); v = int'(aV); hs = int'(aHs); vs = int'(aVs);
                de = int'(aDe); fs = int'(aFs); rgb = int'(aRgb);
            end
            P: begin
                tag = "P"; h = int'(pH); v = int'(pV); hs = int'(pHs); vs = int'(pVs);
                de = int'(pDe); fs = int'(pFs); rgb = int'(pRgb);
            end
            default: begin
                tag = "S"; h = int'(sH); v = int'(sV); hs = int'(sHs); vs = int'(sVs);
                de = int'(sDe); fs = int'(sFs); rgb = int'(sRgb);
            end
        endcase
        tag = $sformatf("%s k=%0d", tag, e.k);
        check({tag, " hCount"}, h, e.h);
        check({tag, " vCount"}, v, e.v);
        check({tag, " hSync"}, hs, e.hs);
        check({tag, " vSync"}, vs, e.vs);
        check({tag, " deOut"}, de, e.de);
        check({tag, " frameStart"}, fs, e.fs);
        check({tag, " rgbOut"}, rgb, e.rgb);
    endtask

    // Monitor: retire every scoreboard entry that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                compare(sb[i]);
                sb.delete(i);
            end
        end
    end

    always @(negedge clk) begin
        if (cntOn) begin
            deCnt = deCnt + int'(sDe);
            if (sFs) fsCyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN = 1'b0; en = 1'b0; rstS = 1'b0; enS = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        // Reset state of all three instances.
        base = cyc;
        expectAt(A, 1, 2199, 1124, 0, 0, 0, 0, 0);
        expectAt(P, 1, 2199, 7, 1, 1, 0, 0, 0);
        expectAt(S, 1, 13, 6, 0, 0, 0, 0, 0);
        waitCyc(base + 1);

        // Default timing and inverted-polarity short-frame instance run together.
        rstN = 1'b1; en = 1'b1; base = cyc;
        expectAt(A, 1,     0,    0, 0, 0, 1, 1, bar(24'hFFFFFF));
        expectAt(A, 2,     1,    0, 0, 0, 1, 0, bar(24'hFFFFFF));
        expectAt(A, 240,   239,  0, 0, 0, 1, 0, bar(24'hFFFFFF));
        expectAt(A, 241,   240,  0, 0, 0, 1, 0, bar(24'hFFFF00));
        expectAt(A, 481,   480,  0, 0, 0, 1, 0, bar(24'h00FFFF));
        expectAt(A, 1680,  1679, 0, 0, 0, 1, 0, bar(24'h0000FF));
        expectAt(A, 1681,  1680, 0, 0, 0, 1, 0, bar(24'h000000));
        expectAt(A, 1920,  1919, 0, 0, 0, 1, 0, bar(24'h000000));
        expectAt(A, 1921,  1920, 0, 0, 0, 0, 0, 0);
        expectAt(A, 2008,  2007, 0, 0, 0, 0, 0, 0);
        expectAt(A, 2009,  2008, 0, 1, 0, 0, 0, 0);
        expectAt(A, 2052,  2051, 0, 1, 0, 0, 0, 0);
        expectAt(A, 2053,  2052, 0, 0, 0, 0, 0, 0);
        expectAt(A, 2200,  2199, 0, 0, 0, 0, 0, 0);
        expectAt(A, 2201,  0,    1, 0, 0, 1, 0, bar(24'hFFFFFF));
        expectAt(A, 17601, 0,    8, 0, 0, 1, 0, bar(24'hFFFFFF));

        expectAt(P, 1,     0,    0, 1, 1, 1, 1, bar(24'hFFFFFF));
        expectAt(P, 2009,  2008, 0, 0, 1, 0, 0, 0);
        expectAt(P, 2052,  2051, 0, 0, 1, 0, 0, 0);
        expectAt(P, 2053,  2052, 0, 1, 1, 0, 0, 0);
        expectAt(P, 8801,  0,    4, 1, 1, 0, 0, 0);
        expectAt(P, 11000, 2199, 4, 1, 1, 0, 0, 0);
        expectAt(P, 11001, 0,    5, 1, 0, 0, 0, 0);
        expectAt(P, 15400, 2199, 6, 1, 0, 0, 0, 0);
        expectAt(P, 15401, 0,    7, 1, 1, 0, 0, 0);
        expectAt(P, 17600, 2199, 7, 1, 1, 0, 0, 0);
        expectAt(P, 17601, 0,    0, 1, 1, 1, 1, bar(24'hFFFFFF));
        waitCyc(base + 17601);

        // Small raster: 14 x 7, with two enable pauses and a mid-frame reset.
        rstS = 1'b1; enS = 1'b1; base = cyc;
        expectAt(S, 1,   0,  0, 0, 0, 1, 1, bar(24'hFFFFFF));
        expectAt(S, 4,   3,  0, 0, 0, 1, 0, bar(24'h00FF00));
        for (int k = 5; k <= 9; k++) expectAt(S, k, 3, 0, 0, 0, 1, 0, bar(24'h00FF00));
        expectAt(S, 10,  4,  0, 0, 0, 1, 0, bar(24'hFF00FF));
        expectAt(S, 104, 0,  0, 0, 0, 1, 1, bar(24'hFFFFFF));
        expectAt(S, 105, 0,  0, 0, 0, 1, 0, bar(24'hFFFFFF));
        expectAt(S, 106, 1,  0, 0, 0, 1, 0, bar(24'hFFFF00));
        expectAt(S, 115, 10, 0, 1, 0, 0, 0, 0);
        expectAt(S, 116, 11, 0, 1, 0, 0, 0, 0);
        expectAt(S, 117, 12, 0, 0, 0, 0, 0, 0);
        expectAt(S, 174, 13, 4, 0, 0, 0, 0, 0);
        expectAt(S, 175, 0,  5, 0, 1, 0, 0, 0);
        expectAt(S, 189, 0,  6, 0, 0, 0, 0, 0);
        expectAt(S, 203, 0,  0, 0, 0, 1, 1, bar(24'hFFFFFF));
        expectAt(S, 432, 5,  2, 0, 0, 1, 0, bar(24'hFF0000));
        expectAt(S, 433, 13, 6, 0, 0, 0, 0, 0);
        expectAt(S, 434, 0,  0, 0, 0, 1, 1, bar(24'hFFFFFF));

        waitCyc(base + 4);   enS = 1'b0;
        waitCyc(base + 9);   enS = 1'b1;
        waitCyc(base + 104); enS = 1'b0;
        waitCyc(base + 105); enS = 1'b1;

        // Two complete frames: 2 x 32 active pixels, frame pulses 98 cycles apart.
        waitCyc(base + 202); cntOn = 1'b1;
        waitCyc(base + 398); cntOn = 1'b0;
        check("S deOut count over two frames", deCnt, 64);
        check("S frameStart pulses over two frames", fsCyc.size(), 2);
        if (fsCyc.size() == 2) check("S frameStart period", fsCyc[1] - fsCyc[0], 98);

        waitCyc(base + 432);
        rstS = 1'b0;
        #1;
        check("S async reset hCount", int'(sH), 13);
        check("S async reset vCount", int'(sV), 6);
        check("S async reset deOut", int'(sDe), 0);
        check("S async reset frameStart", int'(sFs), 0);
        check("S async reset hSync", int'(sHs), 0);
        check("S async reset vSync", int'(sVs), 0);
        check("S async reset rgbOut", int'(sRgb), 0);
        waitCyc(base + 433); rstS = 1'b1;

        waitCyc(base + 436);
        check("scoreboard entries left unchecked", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
